// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time against a word-organised RAM.
// Build option DMEM_MISALIGN_EN: split word-straddling accesses into two beats (else they error).
module dmem_responder #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

`ifdef DMEM_MISALIGN_EN
  localparam int LANES = 8;
`else
  localparam int LANES = 4;
`endif

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd0_q;
`ifdef DMEM_MISALIGN_EN
  logic [31:0] rd1_q;
  logic [AW-1:0] w1;
`endif

  logic [1:0]         off;
  logic [2:0]         size;
  logic [3:0]         mask;
  logic               split;
  logic               bad_f3;
  logic               bad_addr;
  logic               err;
  logic [AW-1:0]      w0;
  logic [LANES-1:0]   be;
  logic [8*LANES-1:0] st_sh;
  logic [31:0]        ld;
  logic [31:0]        ld_fmt;

  assign off      = addr_q[1:0];
  assign w0       = addr_q[AW+1:2];
  assign bad_addr = |addr_q[31:AW+2];
  assign split    = ({2'b00, off} + {1'b0, size}) > 4'd4;

  always_comb begin
    size = 3'd4;
    mask = 4'b1111;
    case (f3_q[1:0])
      2'b00: begin size = 3'd1; mask = 4'b0001; end
      2'b01: begin size = 3'd2; mask = 4'b0011; end
      default: begin size = 3'd4; mask = 4'b1111; end
    endcase
  end

  always_comb begin
    if (we_q) bad_f3 = f3_q[2] | (f3_q[1:0] == 2'b11);
    else      bad_f3 = (f3_q == 3'b011) | (f3_q[2:1] == 2'b11);
  end

`ifdef DMEM_MISALIGN_EN
  assign err = bad_f3 | bad_addr;
  assign w1  = w0 + AW'(1);
  assign ld  = 32'({rd1_q, rd0_q} >> {off, 3'b000});
`else
  assign err = bad_f3 | bad_addr | split;
  assign ld  = 32'(rd0_q >> {off, 3'b000});
`endif

  assign be    = LANES'(mask) << off;
  assign st_sh = (8*LANES)'(wdata_q) << {off, 3'b000};

  // funct3[2] selects zero-extension for LBU/LHU
  always_comb begin
    case (f3_q[1:0])
      2'b00:   ld_fmt = {{24{ld[7] & ~f3_q[2]}}, ld[7:0]};
      2'b01:   ld_fmt = {{16{ld[15] & ~f3_q[2]}}, ld[15:0]};
      default: ld_fmt = ld;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          we_d    = i_req_we;
          f3_d    = i_req_funct3;
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          state_d = ACC1;
        end
      end
      ACC1: begin
`ifdef DMEM_MISALIGN_EN
        state_d = (split && !err) ? ACC2 : RESP;
`else
        state_d = RESP;
`endif
      end
`ifdef DMEM_MISALIGN_EN
      ACC2: state_d = RESP;
`endif
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err;
        rsp_rdata_d = (err || we_q) ? 32'd0 : ld_fmt;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // RAM is deliberately not reset; a reset mid-access simply stops further beats
  always_ff @(posedge i_clk) begin
    if (state_q == ACC1 && !err) begin
      rd0_q <= mem[w0];
      if (we_q) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[w0][8*i +: 8] <= st_sh[8*i +: 8];
        end
      end
    end
`ifdef DMEM_MISALIGN_EN
    if (state_q == ACC2) begin
      rd1_q <= mem[w1];
      if (we_q) begin
        for (int i = 0; i < 4; i++) begin
          if (be[4+i]) mem[w1][8*i +: 8] <= st_sh[32+8*i +: 8];
        end
      end
    end
`endif
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model, directed plan plus random traffic.
module tb_dmem_responder;
  localparam int DEPTH = 512;
  localparam int AW    = $clog2(DEPTH);
  localparam int NB    = DEPTH * 4;
`ifdef DMEM_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [2:0]  i_req_funct3 = 3'd0;
  logic [31:0] i_req_addr = 32'd0;
  logic [31:0] i_req_wdata = 32'd0;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  always #5 i_clk = ~i_clk;

  dmem_responder #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_funct3(i_req_funct3),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          hs;
    int          lat;
    string       name;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  logic [7:0] bmem [NB];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected none", name);
  endtask

  // Byte-level reference: legality, straddle, wrap and extension straight from the rules.
  task automatic model(input bit we, input bit [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output bit err, output logic [31:0] rd,
                       output int lat);
    int size, off, base;
    bit straddle, legal;
    logic [31:0] v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(addr[1:0]);
    straddle = (off + size) > 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err = !legal || (addr >= 32'(NB)) || (straddle && !MIS);
    lat = (straddle && !err) ? 3 : 2;
    rd = 32'd0;
    v = 32'd0;
    if (!err) begin
      base = int'(addr);
      for (int k = 0; k < size; k++) begin
        if (we) bmem[(base + k) % NB] = wd[8*k +: 8];
        else    v[8*k +: 8] = bmem[(base + k) % NB];
      end
      if (!we) begin
        if (size == 1)      rd = f3[2] ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
        else if (size == 2) rd = f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        else                rd = v;
      end
    end
  endtask

  task automatic issue(input string name, input bit we, input bit [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input bit track);
    int   n;
    bit   e_err;
    logic [31:0] e_rd;
    int   e_lat;
    exp_t e;
    n = 0;
    @(negedge i_clk);
    while (!o_req_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_req_ready) begin
      fail_now({name, "_ready_wait"});
      return;
    end
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_funct3 = f3;
    i_req_addr   = addr;
    i_req_wdata  = wd;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    if (track) begin
      model(we, f3, addr, wd, e_err, e_rd, e_lat);
      e.rdata = e_rd;
      e.err   = e_err;
      e.hs    = cyc;
      e.lat   = e_lat;
      e.name  = name;
      sb.push_back(e);
    end
    @(negedge i_clk);
    chk({name, "_ready_busy"}, {31'd0, o_req_ready}, 32'd0);
  endtask

  always @(negedge i_clk) begin : monitor
    exp_t e;
    if (i_reset && o_rsp_valid) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_rsp");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_rdata"}, o_rsp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'd0, o_rsp_err}, {31'd0, e.err});
        chk({e.name, "_latency"}, 32'(cyc - e.hs), 32'(e.lat));
      end
    end
  end

  initial begin
    int r;
    logic [31:0] a;
    for (int i = 0; i < NB; i++) bmem[i] = 8'h00;

    #12;
    chk("reset_ready", {31'd0, o_req_ready}, 32'd1);
    chk("reset_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("reset_rdata", o_rsp_rdata, 32'd0);
    chk("reset_err", {31'd0, o_rsp_err}, 32'd0);
    @(negedge i_clk);
    i_reset = 1'b1;

    for (int w = 0; w <= 16; w++) issue("init_lo", 1'b1, 3'd2, 32'(w*4), $urandom, 1'b1);
    for (int w = DEPTH-4; w < DEPTH; w++) issue("init_hi", 1'b1, 3'd2, 32'(w*4), $urandom, 1'b1);

    issue("sw_10",    1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b1);
    issue("lw_10",    1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
    issue("sb_11",    1'b1, 3'd0, 32'h11, 32'h00000080, 1'b1);
    issue("lb_11",    1'b0, 3'd0, 32'h11, 32'h0, 1'b1);
    issue("lbu_11",   1'b0, 3'd4, 32'h11, 32'h0, 1'b1);
    issue("lw_10b",   1'b0, 3'd2, 32'h10, 32'h0, 1'b1);
    issue("sw_23",    1'b1, 3'd2, 32'h23, 32'h11223344, 1'b1);
    issue("lw_23",    1'b0, 3'd2, 32'h23, 32'h0, 1'b1);
    issue("lw_20",    1'b0, 3'd2, 32'h20, 32'h0, 1'b1);
    issue("lw_24",    1'b0, 3'd2, 32'h24, 32'h0, 1'b1);
    issue("ld_f3_3",  1'b0, 3'd3, 32'h14, 32'h0, 1'b1);
    issue("st_f3_4",  1'b1, 3'd4, 32'h14, 32'hCAFEF00D, 1'b1);
    issue("lw_14",    1'b0, 3'd2, 32'h14, 32'h0, 1'b1);
    issue("lw_800",   1'b0, 3'd2, 32'h800, 32'h0, 1'b1);
    issue("sh_7ff",   1'b1, 3'd1, 32'h7FF, 32'h0000ABCD, 1'b1);
    issue("lhu_7ff",  1'b0, 3'd5, 32'h7FF, 32'h0, 1'b1);
    issue("lbu_7ff",  1'b0, 3'd4, 32'h7FF, 32'h0, 1'b1);
    issue("lbu_000",  1'b0, 3'd4, 32'h000, 32'h0, 1'b1);
    issue("lh_off1",  1'b0, 3'd1, 32'h11, 32'h0, 1'b1);

    // Abort a straddling load one cycle in (ACC2 when splitting is built in).
    issue("rst_ld", 1'b0, 3'd2, 32'h23, 32'h0, 1'b0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, o_req_ready}, 32'd1);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    issue("lw_10_post", 1'b0, 3'd2, 32'h10, 32'h0, 1'b1);

    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = 32'($urandom_range(0, 63));
      else if (r < 9) a = 32'(NB - 16 + $urandom_range(0, 15));
      else            a = 32'($urandom_range(0, 63)) | (32'h1 << $urandom_range(AW+2, 31));
      issue("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b1);
    end

    r = 0;
    while (sb.size() != 0 && r < 50) begin
      @(negedge i_clk);
      r++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
    repeat (3) @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the CPU load/store request interface.
- Accepts one load/store request at a time over a valid/ready handshake and services it from an internal word-organised RAM.
- Returns a one-cycle response pulse. Load data is already extracted and sign/zero-extended per RV32I funct3.
- Misaligned accesses that straddle a word boundary are split into two sequential word beats.

Parameters:
- DEPTH, 512: RAM size in 32-bit words; power of two.
- AW, $clog2(DEPTH): word-index width (derived; not overridden).

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  responder can accept a request
- i_req_we  in  1  1 = store, 0 = load
- i_req_funct3  in  3  RV32I funct3; loads: LB/LH/LW/LBU/LHU; stores: SB/SH/SW
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-aligned
- o_rsp_valid  out  1  one-cycle response pulse
- o_rsp_rdata  out  32  formatted load data; 0 for stores and errors
- o_rsp_err  out  1  error flag, qualified by o_rsp_valid

Behaviour:
- Reset (i_reset=0, async):
  - state=IDLE; o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
  - o_req_ready decodes state, so it reads 1 during reset; requests are ignored while reset is low.
  - RAM contents are not reset.
- FSM states: IDLE, ACC1, ACC2, RESP. o_req_ready=1 only in IDLE.
- IDLE:
  - On i_req_valid & o_req_ready at a clock edge, latch we/funct3/addr/wdata and go to ACC1.
  - No requests are accepted in any other state.
- Request decode (latched fields):
  - off = addr[1:0]; size = 1/2/4 bytes from funct3[1:0].
  - Split iff off+size > 4.
  - Error iff any of:
    - funct3 is illegal for the direction (loads: 011, 110, 111; stores: anything other than 000/001/010);
    - addr[31:AW+2] != 0;
    - split with DMEM_MISALIGN_EN undefined.
- ACC1:
  - If error: go to RESP; no RAM access, no write.
  - Otherwise access word W0 = addr[AW+1:2]. Loads issue a synchronous read; stores write the byte-enabled lanes of W0.
  - Next state: ACC2 if split, else RESP.
- ACC2: access word W1 = (W0+1) mod DEPTH. The wrap at the top of memory is legal and not an error. Next state: RESP.
- Store lanes:
  - 64-bit shifted = {32'b0, wdata} << (8*off).
  - 8-bit byte-enable = size-mask << off.
  - Low 32 bits / low 4 enables go to W0; high halves go to W1.
  - Bytes outside the enable mask are unchanged.
- Load formatting:
  - combined = {word(W1), word(W0)} >> (8*off); take the low 8/16/32 bits.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU.
  - For a non-split access the word(W1) contribution is ignored.
- RESP:
  - o_rsp_valid=1 for exactly one cycle with o_rsp_rdata/o_rsp_err.
  - rdata=0 for stores and errors.
  - Next state: IDLE; outputs return to 0 the following cycle.
- Latency, counted from the handshake edge to the o_rsp_valid cycle: non-split 2 cycles, split 3 cycles.
- Throughput: the next request can be accepted in the cycle after RESP.
- There is no response backpressure; the requester must sample o_rsp_valid.
- Reset mid-operation: aborts immediately. Any W0 write already performed stands; no response is produced.

Optional Feature:
- Macro: DMEM_MISALIGN_EN.
- Defined: word-straddling accesses are split into ACC1+ACC2 as above.
- Undefined:
  - Straddling accesses respond with err=1, rdata=0, no RAM access, latency 2.
  - ACC2 logic is removed.
  - Non-straddling misaligned accesses (e.g. LB anywhere, LH at off=1) still work.

Test Plan:
- Write/read-back: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0, o_rsp_valid exactly 2 cycles after the LW handshake, o_req_ready low in between.
- Byte access: from that state, SB 0x11 data 0x00000080 then:
  - LB 0x11 -> 0xFFFFFF80;
  - LBU 0x11 -> 0x00000080;
  - LW 0x10 -> 0xDEAD80EF.
- Straddling access: SW 0x23 data 0x11223344.
  - With DMEM_MISALIGN_EN defined: byte 0x23=0x44, bytes 0x24..0x26=0x33,0x22,0x11; LW 0x23 -> 0x11223344 at latency 3.
  - With DMEM_MISALIGN_EN undefined: err=1 at latency 2 and words 0x20/0x24 are unchanged.
- Error cases, each -> err=1, rdata=0, no write:
  - load funct3=011;
  - store funct3=100;
  - LW addr 0x800 with DEPTH=512.
- Wrap (DMEM_MISALIGN_EN defined): SH 0x7FF data 0x0000ABCD -> byte 0x7FF=0xCD, byte 0x000=0xAB, err=0; LHU 0x7FF -> 0x0000ABCD.
- Reset mid-operation: pull i_reset low during ACC2 of a split load -> o_rsp_valid=0, o_req_ready=1. After release, LW 0x10 is served normally with latency 2.
